// File: rtl/voice_mixer.sv
// voice_mixer
//
// N-voice sample mixer between the per-voice sample generators and the codec
// conditioner. A one-cycle generate_next_sample request starts a round. The
// mixer collects one sample from every enabled voice, adds them one voice per
// cycle, shifts the sum right by a programmable attenuation, saturates it to
// the codec width and presents the result with a one-cycle valid pulse. If a
// voice never delivers, a timeout ends collection and that voice contributes
// the last sample it delivered.
//
// Ports:
//   clk                  system clock
//   reset                synchronous, active-high reset
//   generate_next_sample one-cycle request to start a mixing round
//   voice_en             per-voice enable mask, latched at round start
//   sample_in            voice i sample at [i*WIDTH +: WIDTH], signed
//   sample_ready         per-voice pulse marking its sample_in slice valid
//   attenuation          arithmetic right shift (0-7), latched at round start
//   mix_out              registered mixed sample, held between rounds
//   mix_valid            one-cycle pulse when mix_out updates
//   clip                 pulse with mix_valid when the result was saturated
//   timeout              pulse with mix_valid when collection timed out
//   overrun              pulse the cycle after a request arrived while busy
//   busy                 high while a round is in progress

module voice_mixer #(
    parameter int NUM_VOICES = 3,
    parameter int WIDTH      = 18,
    parameter int TIMEOUT    = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          generate_next_sample,
    input  logic [NUM_VOICES-1:0]         voice_en,
    input  logic [NUM_VOICES*WIDTH-1:0]   sample_in,
    input  logic [NUM_VOICES-1:0]         sample_ready,
    input  logic [2:0]                    attenuation,
    output logic [WIDTH-1:0]              mix_out,
    output logic                          mix_valid,
    output logic                          clip,
    output logic                          timeout,
    output logic                          overrun,
    output logic                          busy
);

    // The accumulator has room for NUM_VOICES full-scale samples plus a
    // guard bit, so the sum can never wrap before saturation is applied.
    localparam int ACC_W = WIDTH + $clog2(NUM_VOICES) + 1;
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);

    // Output range limits expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SUM     = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_VOICES-1:0]    en_q, en_d;
    logic [2:0]               att_q, att_d;
    logic [NUM_VOICES-1:0]    pending_q, pending_d;
    logic [TMR_W-1:0]         timer_q, timer_d;
    logic                     timed_out_q, timed_out_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]         hold_q [NUM_VOICES];
    logic [WIDTH-1:0]         hold_d [NUM_VOICES];
    logic [WIDTH-1:0]         mix_out_q, mix_out_d;
    logic                     mix_valid_q, mix_valid_d;
    logic                     clip_q, clip_d;
    logic                     timeout_q, timeout_d;
    logic                     overrun_q, overrun_d;
    logic                     busy_q, busy_d;

    logic [NUM_VOICES-1:0]    captured;
    logic [NUM_VOICES-1:0]    pending_left;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  shifted;

    // Next-state logic for the whole round: request acceptance, sample
    // capture, sequential summation and the final shift/saturate step.
    always_comb begin
        state_d      = state_q;
        en_d         = en_q;
        att_d        = att_q;
        pending_d    = pending_q;
        timer_d      = timer_q;
        timed_out_d  = timed_out_q;
        idx_d        = idx_q;
        acc_d        = acc_q;
        hold_d       = hold_q;
        mix_out_d    = mix_out_q;
        mix_valid_d  = 1'b0;
        clip_d       = 1'b0;
        timeout_d    = 1'b0;
        overrun_d    = generate_next_sample & busy_q;
        captured     = '0;
        pending_left = '0;
        addend       = '0;
        shifted      = '0;

        case (state_q)
            IDLE: begin
                // Accumulator and voice index are cleared here so SUM
                // always starts from zero, whichever state it is entered from.
                acc_d = '0;
                idx_d = '0;
                if (generate_next_sample) begin
                    en_d        = voice_en;
                    att_d       = attenuation;
                    timer_d     = '0;
                    timed_out_d = 1'b0;
                    // A voice that is already ready in the accepting cycle
                    // counts as delivered for this round.
                    captured    = sample_ready & voice_en;
                    pending_d   = voice_en & ~captured;
                    state_d     = (voice_en == '0) ? SUM : COLLECT;
                end
            end

            COLLECT: begin
                acc_d        = '0;
                idx_d        = '0;
                captured     = sample_ready & pending_q;
                pending_left = pending_q & ~captured;
                pending_d    = pending_left;
                // A voice arriving in the final timer cycle still makes it in,
                // because capture is evaluated before the timeout decision.
                if (pending_left == '0) begin
                    state_d = SUM;
                end else if (timer_q == TMR_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = SUM;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            SUM: begin
                // Disabled voices add zero; timed-out voices add their
                // previously held sample.
                if (en_q[idx_q]) begin
                    addend = {{(ACC_W - WIDTH){hold_q[idx_q][WIDTH-1]}}, hold_q[idx_q]};
                end
                acc_d = acc_q + addend;
                if (idx_q == IDX_LAST) begin
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            OUT: begin
                shifted = acc_q >>> att_q;
                if (shifted > SAT_MAX) begin
                    mix_out_d = SAT_MAX[WIDTH-1:0];
                    clip_d    = 1'b1;
                end else if (shifted < SAT_MIN) begin
                    mix_out_d = SAT_MIN[WIDTH-1:0];
                    clip_d    = 1'b1;
                end else begin
                    mix_out_d = shifted[WIDTH-1:0];
                end
                mix_valid_d = 1'b1;
                timeout_d   = timed_out_q;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        for (int i = 0; i < NUM_VOICES; i++) begin
            if (captured[i]) begin
                hold_d[i] = sample_in[i*WIDTH +: WIDTH];
            end
        end

        busy_d = (state_d != IDLE);
    end

    // All state and outputs are registered; reset aborts any round in flight
    // without producing a valid pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            en_q        <= '0;
            att_q       <= '0;
            pending_q   <= '0;
            timer_q     <= '0;
            timed_out_q <= 1'b0;
            idx_q       <= '0;
            acc_q       <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                hold_q[i] <= '0;
            end
            mix_out_q   <= '0;
            mix_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            att_q       <= att_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            timed_out_q <= timed_out_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                hold_q[i] <= hold_d[i];
            end
            mix_out_q   <= mix_out_d;
            mix_valid_q <= mix_valid_d;
            clip_q      <= clip_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign mix_out   = mix_out_q;
    assign mix_valid = mix_valid_q;
    assign clip      = clip_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_voice_mixer.sv
// tb_voice_mixer
//
// Bench for voice_mixer with NUM_VOICES=3, WIDTH=18, TIMEOUT=64. A table of
// hand-computed rounds is applied first, then hand-written overrun and
// mid-round reset sequences, then randomized rounds whose expectations come
// from a small arithmetic model of the mixer (held samples, sum, shift, clamp).

module tb_voice_mixer;

    localparam int N      = 3;
    localparam int W      = 18;
    localparam int TO     = 64;
    localparam int SAT_HI = 131071;
    localparam int SAT_LO = -131072;
    localparam logic [7:0] NEVER = 8'hFF;

    logic            clk = 1'b0;
    logic            reset;
    logic            generate_next_sample;
    logic [N-1:0]    voice_en;
    logic [N*W-1:0]  sample_in;
    logic [N-1:0]    sample_ready;
    logic [2:0]      attenuation;
    logic [W-1:0]    mix_out;
    logic            mix_valid;
    logic            clip;
    logic            timeout;
    logic            overrun;
    logic            busy;

    // One round: inputs, per-voice ready cycle offsets (NEVER = no pulse),
    // and the expected result with the cycle offset of the valid pulse.
    typedef struct packed {
        logic [2:0]       en;
        logic [2:0]       att;
        logic [2:0][17:0] smp;
        logic [2:0][7:0]  rdy;
        logic [17:0]      exp_out;
        logic             exp_clip;
        logic             exp_to;
        logic [7:0]       exp_lat;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int model_hold [N];

    voice_mixer #(
        .NUM_VOICES (N),
        .WIDTH      (W),
        .TIMEOUT    (TO)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .generate_next_sample (generate_next_sample),
        .voice_en             (voice_en),
        .sample_in            (sample_in),
        .sample_ready         (sample_ready),
        .attenuation          (attenuation),
        .mix_out              (mix_out),
        .mix_valid            (mix_valid),
        .clip                 (clip),
        .timeout              (timeout),
        .overrun              (overrun),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int en, att, s0, s1, s2, r0, r1, r2,
                                input int out, clp, to, lat);
        vec_t r;
        r = '0;
        r.en       = 3'(en);
        r.att      = 3'(att);
        r.smp[0]   = 18'(s0);
        r.smp[1]   = 18'(s1);
        r.smp[2]   = 18'(s2);
        r.rdy[0]   = (r0 < 0) ? NEVER : 8'(r0);
        r.rdy[1]   = (r1 < 0) ? NEVER : 8'(r1);
        r.rdy[2]   = (r2 < 0) ? NEVER : 8'(r2);
        r.exp_out  = 18'(out);
        r.exp_clip = 1'(clp);
        r.exp_to   = 1'(to);
        r.exp_lat  = 8'(lat);
        return r;
    endfunction

    // A voice delivers in a round when it is enabled and pulses no later
    // than TIMEOUT cycles after the request.
    function automatic bit delivers(input vec_t v, input int i);
        return v.en[i] && (v.rdy[i] != NEVER) && (int'(v.rdy[i]) <= TO);
    endfunction

    function automatic vec_t predict(input vec_t v);
        vec_t r;
        int   sum;
        int   s;
        int   last_rdy;
        bit   to;
        r        = v;
        sum      = 0;
        to       = 1'b0;
        last_rdy = 1;
        for (int i = 0; i < N; i++) begin
            if (v.en[i]) begin
                if (delivers(v, i)) begin
                    sum += int'($signed(v.smp[i]));
                    if (int'(v.rdy[i]) > last_rdy) last_rdy = int'(v.rdy[i]);
                end else begin
                    sum += model_hold[i];
                    to = 1'b1;
                end
            end
        end
        s = sum >>> int'(v.att);
        r.exp_clip = (s > SAT_HI) || (s < SAT_LO);
        if (s > SAT_HI) s = SAT_HI;
        if (s < SAT_LO) s = SAT_LO;
        r.exp_out = 18'(s);
        r.exp_to  = to;
        if (v.en == 3'b000)  r.exp_lat = 8'(N + 2);
        else if (to)         r.exp_lat = 8'(TO + N + 2);
        else                 r.exp_lat = 8'(last_rdy + N + 2);
        return r;
    endfunction

    task automatic updateModel(input vec_t v);
        for (int i = 0; i < N; i++) begin
            if (delivers(v, i)) model_hold[i] = int'($signed(v.smp[i]));
        end
    endtask

    // Drives one round starting at offset 0 and watches every following
    // cycle up to two past the expected valid pulse. Each voice pulses at its
    // ready offset and again one cycle later with junk data; enables and
    // attenuation are scrambled after the request cycle.
    task automatic applyStimulus(input vec_t v, input string tag);
        int   last;
        int   vcyc;
        int   vcount;
        int   got_out;
        int   got_clip;
        int   got_to;
        int   busy1;
        int   busyv;
        int   ovr;
        last     = int'(v.exp_lat) + 2;
        vcyc     = -1;
        vcount   = 0;
        got_out  = 0;
        got_clip = 0;
        got_to   = 0;
        busy1    = 0;
        busyv    = 1;
        ovr      = 0;
        for (int c = 0; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = int'(busy);
            if (c > 0 && mix_valid) begin
                vcount++;
                if (vcyc < 0) begin
                    vcyc     = c;
                    got_out  = int'($signed(mix_out));
                    got_clip = int'(clip);
                    got_to   = int'(timeout);
                    busyv    = int'(busy);
                end
            end
            if (c > 0 && overrun) ovr = 1;
            generate_next_sample = (c == 0);
            voice_en             = (c == 0) ? v.en : 3'($urandom);
            attenuation          = (c == 0) ? v.att : 3'($urandom);
            sample_ready         = '0;
            for (int i = 0; i < N; i++) begin
                sample_in[i*W +: W] = W'($urandom);
                if (v.rdy[i] != NEVER && c == int'(v.rdy[i])) begin
                    sample_ready[i]     = 1'b1;
                    sample_in[i*W +: W] = v.smp[i];
                end else if (v.rdy[i] != NEVER && c == int'(v.rdy[i]) + 1) begin
                    sample_ready[i] = 1'b1;
                end
            end
        end
        checkOutput($sformatf("%s valid_cycle", tag), vcyc, int'(v.exp_lat));
        checkOutput($sformatf("%s valid_count", tag), vcount, 1);
        checkOutput($sformatf("%s mix_out", tag), got_out, int'($signed(v.exp_out)));
        checkOutput($sformatf("%s clip", tag), got_clip, int'(v.exp_clip));
        checkOutput($sformatf("%s timeout", tag), got_to, int'(v.exp_to));
        checkOutput($sformatf("%s busy_start", tag), busy1, 1);
        checkOutput($sformatf("%s busy_at_valid", tag), busyv, 0);
        checkOutput($sformatf("%s overrun", tag), ovr, 0);
        updateModel(v);
    endtask

    vec_t tbl [18];

    initial begin
        vec_t v;
        int   vcount;
        int   vfirst;
        int   vsecond;
        int   out1;
        int   out2;
        int   ovr_count;
        int   ovr_cyc;
        int   busy_mid;
        int   busy_rst;
        int   out_rst;
        int   r;

        reset                = 1'b1;
        generate_next_sample = 1'b0;
        voice_en             = '0;
        sample_in            = '0;
        sample_ready         = '0;
        attenuation          = '0;
        for (int i = 0; i < N; i++) model_hold[i] = 0;

        repeat (3) @(negedge clk);
        checkOutput("reset mix_out", int'(mix_out), 0);
        checkOutput("reset mix_valid", int'(mix_valid), 0);
        checkOutput("reset clip", int'(clip), 0);
        checkOutput("reset timeout", int'(timeout), 0);
        checkOutput("reset overrun", int'(overrun), 0);
        checkOutput("reset busy", int'(busy), 0);
        reset = 1'b0;

        // en, att, samples 0..2, ready offsets 0..2 (-1 never), out, clip, to, latency
        tbl[0]  = mk(7, 0, 1000, -300, 50, 1, 1, 1, 750, 0, 0, 6);
        tbl[1]  = mk(7, 0, 100000, 100000, 100000, 1, 1, 1, 131071, 1, 0, 6);
        tbl[2]  = mk(7, 0, -100000, -100000, -100000, 1, 1, 1, -131072, 1, 0, 6);
        tbl[3]  = mk(7, 2, 1000, -300, 50, 1, 1, 1, 187, 0, 0, 6);
        tbl[4]  = mk(7, 2, -1000, 300, -50, 1, 1, 1, -188, 0, 0, 6);
        tbl[5]  = mk(7, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 6);
        tbl[6]  = mk(7, 0, 400, 200, 999, 1, 1, -1, 600, 0, 1, 69);
        tbl[7]  = mk(7, 0, 400, 200, 7, 3, 3, 3, 607, 0, 0, 8);
        tbl[8]  = mk(5, 0, 10, 5000, 20, 1, 1, 1, 30, 0, 0, 6);
        tbl[9]  = mk(0, 0, 11111, 22222, -33333, 0, 0, 0, 0, 0, 0, 5);
        tbl[10] = mk(7, 0, 1, 2, 3, 0, 0, 0, 6, 0, 0, 6);
        tbl[11] = mk(7, 0, 5, -6, 7, 2, 5, 0, 6, 0, 0, 10);
        tbl[12] = mk(2, 0, 900, 901, 902, -1, -1, -1, -6, 0, 1, 69);
        tbl[13] = mk(1, 0, 123, 0, 0, 64, -1, -1, 123, 0, 0, 69);
        tbl[14] = mk(1, 0, 999, 0, 0, 65, -1, -1, 123, 0, 1, 69);
        tbl[15] = mk(7, 7, -1, -1, -1, 1, 1, 1, -1, 0, 0, 6);
        tbl[16] = mk(7, 1, 131071, 131071, 131071, 1, 1, 1, 131071, 1, 0, 6);
        tbl[17] = mk(7, 2, 131071, 131071, 131071, 1, 1, 1, 98303, 0, 0, 6);

        for (int i = 0; i < 18; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // Request during SUM is dropped with an overrun pulse; a request in
        // the valid cycle itself starts a fresh round.
        vcount    = 0;
        vfirst    = -1;
        vsecond   = -1;
        out1      = 0;
        out2      = 0;
        ovr_count = 0;
        ovr_cyc   = -1;
        for (int c = 0; c <= 14; c++) begin
            @(negedge clk);
            if (mix_valid) begin
                if (vcount == 0) begin
                    vfirst = c;
                    out1   = int'($signed(mix_out));
                end else if (vcount == 1) begin
                    vsecond = c;
                    out2    = int'($signed(mix_out));
                end
                vcount++;
            end
            if (overrun) begin
                ovr_count++;
                ovr_cyc = c;
            end
            generate_next_sample = (c == 0 || c == 3 || c == 6);
            voice_en             = 3'b111;
            attenuation          = 3'd0;
            sample_ready         = (c == 1 || c == 7) ? 3'b111 : 3'b000;
            sample_in            = {3{(c < 7) ? 18'd1 : 18'd2}};
        end
        checkOutput("ovr first_valid_cycle", vfirst, 6);
        checkOutput("ovr first_mix_out", out1, 3);
        checkOutput("ovr second_valid_cycle", vsecond, 12);
        checkOutput("ovr second_mix_out", out2, 6);
        checkOutput("ovr valid_count", vcount, 2);
        checkOutput("ovr overrun_count", ovr_count, 1);
        checkOutput("ovr overrun_cycle", ovr_cyc, 4);
        for (int i = 0; i < N; i++) model_hold[i] = 2;

        // Reset in the middle of collection aborts the round silently and
        // clears the held samples.
        vcount   = 0;
        busy_mid = 0;
        busy_rst = 1;
        out_rst  = -1;
        for (int c = 0; c <= 80; c++) begin
            @(negedge clk);
            if (c == 2) busy_mid = int'(busy);
            if (c == 4) begin
                busy_rst = int'(busy);
                out_rst  = int'($signed(mix_out));
            end
            if (c >= 4 && mix_valid) vcount++;
            generate_next_sample = (c == 0);
            voice_en             = 3'b111;
            attenuation          = 3'd0;
            sample_ready         = '0;
            sample_in            = '0;
            reset                = (c == 3);
        end
        checkOutput("rst busy_before", busy_mid, 1);
        checkOutput("rst busy_after", busy_rst, 0);
        checkOutput("rst mix_out_after", out_rst, 0);
        checkOutput("rst no_valid", vcount, 0);
        for (int i = 0; i < N; i++) model_hold[i] = 0;

        applyStimulus(mk(3, 0, 0, 0, 0, -1, -1, -1, 0, 0, 1, 69), "post_rst_hold");
        applyStimulus(mk(7, 0, 10, 20, 30, 1, 2, 3, 60, 0, 0, 8), "post_rst_round");

        // Randomized rounds checked against the arithmetic model.
        for (int k = 0; k < 25; k++) begin
            v     = '0;
            v.en  = 3'($urandom_range(0, 7));
            v.att = 3'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                v.smp[i] = 18'($urandom_range(0, 262143));
                r = $urandom_range(0, 15);
                if (r == 15)      v.rdy[i] = NEVER;
                else if (r == 14) v.rdy[i] = 8'd70;
                else              v.rdy[i] = 8'(r % 11);
            end
            v = predict(v);
            applyStimulus(v, $sformatf("rnd%0d", k));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised N-voice mixer between the per-voice sample generators and the codec conditioner of the music player. On each `generate_next_sample` request it collects one sample from every enabled voice and sums them sequentially. It then applies a programmable attenuation, saturates the result to the codec width and presents one registered mixed sample with a single-cycle valid pulse. A missing voice is covered by a timeout that reuses that voice's last held sample.

## Interface

Parameters:
- `NUM_VOICES`, 3, number of voice channels (≥1).
- `WIDTH`, 18, signed two's-complement sample width, for both the inputs and the output.
- `TIMEOUT`, 64, maximum number of COLLECT cycles before the mixer forces a sum.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `generate_next_sample`  in  1  one-cycle request that starts a mixing round.
- `voice_en`  in  NUM_VOICES  voice enable mask; sampled at round start.
- `sample_in`  in  NUM_VOICES*WIDTH  voice i sample at `[i*WIDTH +: WIDTH]`.
- `sample_ready`  in  NUM_VOICES  per-voice pulse: `sample_in` slice i is valid this cycle.
- `attenuation`  in  3  arithmetic right shift (0–7) applied after summation; sampled at round start.
- `mix_out`  out  WIDTH  registered mixed sample; held between rounds.
- `mix_valid`  out  1  one-cycle pulse when `mix_out` updates.
- `clip`  out  1  pulse concurrent with `mix_valid` when saturation occurred.
- `timeout`  out  1  pulse concurrent with `mix_valid` when the round ended by timeout.
- `overrun`  out  1  one-cycle pulse, the cycle after a `generate_next_sample` arrives while `busy`.
- `busy`  out  1  high in COLLECT, SUM and OUT.

## Operation

- States:
  - IDLE: waits for a request.
  - COLLECT: `pending` mask, `timer` counter.
  - SUM: `idx` counter, accumulator `acc` of WIDTH+$clog2(NUM_VOICES)+1 bits.
  - OUT: computes and registers the result.
- IDLE, on `generate_next_sample`:
  - Latch `en_q`=`voice_en` and `att_q`=`attenuation`.
  - Set `pending`=`voice_en`, `timer`=0 and clear the timed-out flag.
  - Go to COLLECT, or go directly to SUM if `voice_en`=0.
  - Any `sample_ready[i]` in the same cycle with `voice_en[i]`=1 is captured and that bit is cleared from `pending`.
- COLLECT: for each i with `sample_ready[i] & pending[i]`, `hold[i]`←slice i and `pending[i]` is cleared.
  - Ready pulses from non-pending voices are ignored; `hold` is unchanged.
  - Ready pulses in any state other than COLLECT or the accepting IDLE cycle are ignored.
- COLLECT exit:
  - If `pending` is zero after this cycle's captures, go to SUM.
  - Otherwise, if `timer`=TIMEOUT-1, set the timed-out flag and go to SUM.
  - Otherwise increment `timer`.
- SUM:
  - Clear `acc` on entry.
  - For idx=0..NUM_VOICES-1, one voice per cycle: `acc` += `en_q[idx]` ? sign-extend(`hold[idx]`) : 0.
  - After the last idx, go to OUT.
- OUT:
  - `s` = `acc` >>> `att_q` (arithmetic shift).
  - Saturate `s` to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Register `mix_out`. Pulse `mix_valid`. Pulse `clip` if saturation occurred. Pulse `timeout` if the timed-out flag is set.
  - Go to IDLE.
- A timed-out voice contributes its previous `hold` value (0 after reset).
- `generate_next_sample` while `busy` is dropped; it does not queue a round and it raises `overrun`.

## Timing

- Reset, synchronous:
  - State←IDLE; all `hold`, `acc`, `timer`, `pending` and `en_q`←0.
  - `mix_out`=0; `mix_valid`, `clip`, `timeout`, `overrun` and `busy`=0.
  - Reset mid-round aborts the round with no `mix_valid`.
- Request at cycle T, all voices ready at T+1: SUM spans T+2..T+1+N, OUT is at T+2+N, `mix_valid` is high at T+3+N (T+6 for N=3).
- Timeout: COLLECT spans T+1..T+TIMEOUT, `mix_valid` is high at T+TIMEOUT+N+2.
- `voice_en`=0: SUM spans T+1..T+N, `mix_valid` is high at T+N+2 with `mix_out`=0.
- `busy` is high from T+1 through the OUT cycle. It is low in the `mix_valid` cycle, so a request in that cycle is accepted.

## Test plan

1. N=3, `attenuation`=0, all enabled, samples 1000/-300/50 ready at T+1 -> `mix_out`=750 and `mix_valid` high only at T+6; `clip`=0, `timeout`=0.
2. Samples 100000 ×3 -> `mix_out`=131071, `clip`=1. Samples -100000 ×3 -> `mix_out`=-131072, `clip`=1.
3. `attenuation`=2, samples 1000/-300/50 -> `mix_out`=187. Samples -1000/300/-50 -> `mix_out`=-188.
4. Voice 2 held at 0 and never ready, voices 0/1 = 400/200 -> `mix_out`=600 and `timeout`=1 at T+69 (TIMEOUT=64); the next round with voice 2 ready proceeds normally.
5. `voice_en`=3'b101, voice 1 ready with 5000, voices 0/2 = 10/20 -> `mix_out`=30. Then `voice_en`=0 -> `mix_out`=0 at T+5.
6. Request during SUM -> `overrun` pulse the next cycle and only one `mix_valid` is produced. `reset` during COLLECT -> all outputs 0 and IDLE; the next request completes normally.
